// File: rtl/tick_timer_scheduler_if.sv
// Request/grant bundle between the tick timer scheduler and its client blocks.
// The scheduler takes the slave modport; the client side takes the master modport.
interface tick_timer_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8
);
  logic [NUM_REQ-1:0]             request;
  logic [NUM_REQ*COUNT_WIDTH-1:0] duration;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;
  logic [COUNT_WIDTH-1:0]         remaining;

  modport master (
    output request, duration,
    input  grant, done, busy, remaining
  );

  modport slave (
    input  request, duration,
    output grant, done, busy, remaining
  );
endinterface

// File: rtl/tick_timer_scheduler.sv
// Round-robin owner of the shared 1 Hz timebase: runs one whole-second countdown at
// a time and enables the divider only while that countdown is active.
module tick_timer_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 clear_n,
  input  logic                 clock_1Hz,
  output logic                 divider_enable,
  tick_timer_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       ptr_next;
  logic                   clock_1Hz_d;
  logic                   tick;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [IDX_W:0]         cand_wide;
  logic [IDX_W-1:0]       cand;
  logic                   owner_req;
  logic [COUNT_WIDTH-1:0] owner_dur;

  assign tick      = clock_1Hz & ~clock_1Hz_d;
  // grant is the registered one-hot of the winner, so it doubles as the owner select
  assign owner_req = |(bus.request & bus.grant);
  assign ptr_next  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand_wide  = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_wide = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand_wide >= (IDX_W + 1)'(NUM_REQ)) begin
        cand_wide = cand_wide - (IDX_W + 1)'(NUM_REQ);
      end
      cand = cand_wide[IDX_W-1:0];
      if (!win_found && bus.request[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = (IDX_W'(i) == win_idx);
    end
  end

  always_comb begin
    owner_dur = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.grant[i]) begin
        owner_dur = bus.duration[i*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state          <= IDLE;
      ptr            <= '0;
      winner         <= '0;
      clock_1Hz_d    <= 1'b0;
      divider_enable <= 1'b0;
      bus.grant      <= '0;
      bus.done       <= '0;
      bus.busy       <= 1'b0;
      bus.remaining  <= '0;
    end else begin
      clock_1Hz_d <= clock_1Hz;
      case (state)
        IDLE: begin
          divider_enable <= 1'b0;
          bus.done       <= '0;
          if (win_found) begin
            winner    <= win_idx;
            bus.grant <= win_onehot;
            bus.busy  <= 1'b1;
            state     <= LOAD;
          end else begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
          end
        end

        LOAD: begin
          if (!owner_req) begin
            state          <= IDLE;
            ptr            <= ptr_next;
            bus.grant      <= '0;
            bus.busy       <= 1'b0;
            bus.remaining  <= '0;
            divider_enable <= 1'b0;
          end else begin
            bus.remaining <= owner_dur;
            if (owner_dur == '0) begin
              state          <= DONE;
              bus.done       <= bus.grant;
              divider_enable <= 1'b0;
            end else begin
              state          <= RUN;
              divider_enable <= 1'b1;
            end
          end
        end

        RUN: begin
          // A withdrawn request wins over a coincident tick: the job ends silently
          if (!owner_req) begin
            state          <= IDLE;
            ptr            <= ptr_next;
            bus.grant      <= '0;
            bus.busy       <= 1'b0;
            bus.remaining  <= '0;
            divider_enable <= 1'b0;
          end else if (tick && (bus.remaining != '0)) begin
            bus.remaining <= bus.remaining - 1'b1;
            if (bus.remaining == COUNT_WIDTH'(1)) begin
              state          <= DONE;
              bus.done       <= bus.grant;
              divider_enable <= 1'b0;
            end
          end
        end

        DONE: begin
          state          <= IDLE;
          ptr            <= ptr_next;
          bus.grant      <= '0;
          bus.done       <= '0;
          bus.busy       <= 1'b0;
          divider_enable <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          bus.grant      <= '0;
          bus.done       <= '0;
          bus.busy       <= 1'b0;
          divider_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Bench for tick_timer_scheduler: directed scenarios plus random requests, all
// compared every cycle against a job-level model of the scheduler.
module tb_tick_timer_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int COUNT_WIDTH = 8;

  logic clock     = 1'b0;
  logic clear_n   = 1'b1;
  logic clock_1Hz = 1'b0;
  logic divider_enable;

  tick_timer_scheduler_if #(.NUM_REQ(NUM_REQ), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  tick_timer_scheduler #(.NUM_REQ(NUM_REQ), .COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clock          (clock),
    .clear_n        (clear_n),
    .clock_1Hz      (clock_1Hz),
    .divider_enable (divider_enable),
    .bus            (bus.slave)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ*COUNT_WIDTH-1:0] dur);
    bus.request  = req;
    bus.duration = dur;
  endtask

  // Divider stand-in: a square wave that flips every 10 system cycles
  bit hz_run = 1'b0;
  int hz_cnt = 0;
  always @(negedge clock) begin
    if (hz_run) begin
      if (hz_cnt == 9) begin
        hz_cnt    = 0;
        clock_1Hz = ~clock_1Hz;
      end else begin
        hz_cnt++;
      end
    end
  end

  // Job-level model: who owns the timebase, whether the duration has been taken,
  // seconds left, and whether the job is in its completion cycle.
  int m_owner  = -1;
  int m_left   = 0;
  int m_ptr    = 0;
  bit m_loaded = 1'b0;
  bit m_finish = 1'b0;
  bit m_prev   = 1'b0;

  task automatic model_step();
    bit rise;
    if (!clear_n) begin
      m_owner  = -1;
      m_left   = 0;
      m_ptr    = 0;
      m_loaded = 1'b0;
      m_finish = 1'b0;
      m_prev   = 1'b0;
      return;
    end
    rise   = clock_1Hz && !m_prev;
    m_prev = clock_1Hz;
    if (m_owner < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c = (m_ptr + k) % NUM_REQ;
        if (bus.request[c]) begin
          m_owner  = c;
          m_loaded = 1'b0;
          break;
        end
      end
    end else if (m_finish) begin
      m_ptr    = (m_owner + 1) % NUM_REQ;
      m_owner  = -1;
      m_finish = 1'b0;
    end else if (!bus.request[m_owner]) begin
      m_left  = 0;
      m_ptr   = (m_owner + 1) % NUM_REQ;
      m_owner = -1;
    end else if (!m_loaded) begin
      m_left   = int'(bus.duration[m_owner*COUNT_WIDTH +: COUNT_WIDTH]);
      m_loaded = 1'b1;
      m_finish = (m_left == 0);
    end else if (rise) begin
      m_left   = m_left - 1;
      m_finish = (m_left == 0);
    end
  endtask

  task automatic compare_all();
    logic [NUM_REQ-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg = NUM_REQ'(1) << m_owner;
    check_output("cyc_grant", 32'(bus.grant), 32'(eg));
    check_output("cyc_done", 32'(bus.done), m_finish ? 32'(eg) : 32'd0);
    check_output("cyc_busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_output("cyc_remaining", 32'(bus.remaining), 32'(m_left));
    check_output("cyc_divider_enable", 32'(divider_enable),
                 (m_owner >= 0 && m_loaded && !m_finish) ? 32'd1 : 32'd0);
  endtask

  always @(posedge clock) begin
    model_step();
    #1;
    compare_all();
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int onehot_index(input logic [NUM_REQ-1:0] v);
    int idx = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  initial begin
    int rr_order [6] = '{0, 1, 3, 0, 1, 3};
    int seq_exp [3]  = '{3, 2, 1};
    int seq [$];
    int last;
    bit seen;

    apply_stimulus('0, '0);
    clear_n = 1'b0;
    #97 clear_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      check_output("idle_outputs",
                   32'({divider_enable, bus.busy, bus.grant, bus.done, bus.remaining}), 32'd0);
    end

    // Single job on requester 1, three seconds
    hz_run = 1'b1;
    @(negedge clock);
    apply_stimulus(4'b0010, 32'h0000_0300);
    @(negedge clock);
    check_output("single_grant", 32'(bus.grant), 32'h2);
    last = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (bus.done != '0) begin
        seen = 1'b1;
        check_output("single_done", 32'(bus.done), 32'h2);
        check_output("single_done_remaining", 32'(bus.remaining), 32'd0);
        check_output("single_done_div_en", 32'(divider_enable), 32'd0);
        bus.request = '0;
      end else if (int'(bus.remaining) != last) begin
        last = int'(bus.remaining);
        seq.push_back(last);
        if (seq.size() == 1) check_output("single_run_div_en", 32'(divider_enable), 32'd1);
      end
    end
    check_output("single_done_seen", 32'(seen), 32'd1);
    check_output("single_seq_len", 32'(seq.size()), 32'd3);
    for (int i = 0; i < 3 && i < seq.size(); i++) check_output("single_seq", 32'(seq[i]), 32'(seq_exp[i]));
    @(negedge clock);
    check_output("single_after_grant", 32'(bus.grant), 32'd0);
    check_output("single_after_done", 32'(bus.done), 32'd0);
    check_output("single_after_div_en", 32'(divider_enable), 32'd0);

    // Round-robin from a fresh pointer
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    apply_stimulus(4'b1011, {4{8'd1}});
    for (int j = 0; j < 6; j++) begin
      logic [NUM_REQ-1:0] g;
      seen = 1'b0;
      g = '0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clock);
        if (bus.grant != '0) begin
          seen = 1'b1;
          g = bus.grant;
        end
      end
      check_output("rr_grant_seen", 32'(seen), 32'd1);
      check_output("rr_grant_order", 32'(onehot_index(g)), 32'(rr_order[j]));
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clock);
        if (bus.done != '0) begin
          seen = 1'b1;
          check_output("rr_done_owner", 32'(bus.done), 32'(g));
        end
      end
      check_output("rr_done_seen", 32'(seen), 32'd1);
      @(negedge clock);
      check_output("rr_single_done", 32'(bus.done), 32'd0);
      check_output("rr_idle_gap", 32'(bus.grant), 32'd0);
    end
    apply_stimulus('0, '0);
    repeat (4) @(negedge clock);

    // Zero duration on requester 2
    apply_stimulus(4'b0100, 32'h0000_0000);
    @(negedge clock);
    check_output("zero_grant", 32'(bus.grant), 32'h4);
    check_output("zero_load_done", 32'(bus.done), 32'd0);
    check_output("zero_load_div_en", 32'(divider_enable), 32'd0);
    @(negedge clock);
    check_output("zero_done", 32'(bus.done), 32'h4);
    check_output("zero_done_div_en", 32'(divider_enable), 32'd0);
    bus.request = '0;
    @(negedge clock);
    check_output("zero_idle_grant", 32'(bus.grant), 32'd0);
    repeat (2) @(negedge clock);

    // Abort requester 0 after two seconds
    apply_stimulus(4'b0001, 32'h0000_0005);
    @(negedge clock);
    check_output("abort_grant", 32'(bus.grant), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (bus.remaining == 8'd3) seen = 1'b1;
    end
    check_output("abort_two_ticks_seen", 32'(seen), 32'd1);
    bus.request = '0;
    @(negedge clock);
    check_output("abort_grant_clear", 32'(bus.grant), 32'd0);
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_no_done", 32'(bus.done), 32'd0);
    check_output("abort_remaining", 32'(bus.remaining), 32'd0);
    check_output("abort_div_en", 32'(divider_enable), 32'd0);
    apply_stimulus(4'b0011, 32'h0000_0202);
    @(negedge clock);
    check_output("abort_ptr_advanced", 32'(bus.grant), 32'h2);
    apply_stimulus('0, '0);
    repeat (3) @(negedge clock);

    // Asynchronous reset in the middle of a countdown
    apply_stimulus(4'b1001, 32'h0600_0002);
    @(negedge clock);
    check_output("reset_pre_grant", 32'(bus.grant), 32'h8);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (bus.remaining == 8'd4) seen = 1'b1;
    end
    check_output("reset_rem4_seen", 32'(seen), 32'd1);
    clear_n = 1'b0;
    #1;
    check_output("reset_async_grant", 32'(bus.grant), 32'd0);
    check_output("reset_async_done", 32'(bus.done), 32'd0);
    check_output("reset_async_busy", 32'(bus.busy), 32'd0);
    check_output("reset_async_remaining", 32'(bus.remaining), 32'd0);
    check_output("reset_async_div_en", 32'(divider_enable), 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    check_output("reset_regrant_ptr0", 32'(bus.grant), 32'h1);

    // Random traffic: requests come and go, some are held past done, some withdrawn
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.request[i] && bus.done[i]) begin
          if ($urandom_range(1, 0) == 0) bus.request[i] = 1'b0;
        end else if (!bus.request[i]) begin
          if ($urandom_range(15, 0) == 0) begin
            bus.request[i] = 1'b1;
            bus.duration[i*COUNT_WIDTH +: COUNT_WIDTH] = COUNT_WIDTH'($urandom_range(4, 0));
          end
        end else if ($urandom_range(99, 0) == 0) begin
          bus.request[i] = 1'b0;
        end
      end
    end
    apply_stimulus('0, '0);
    repeat (5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
